// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture-side signal bundle for pwm_capture.
//   en_i / in_i          : capture enable and raw (asynchronous) PWM line
//   high_count_o         : last measured high time, clk cycles
//   period_count_o       : last measured rise-to-rise period, clk cycles
//   duty_o               : last normalised duty code
//   valid_o              : one-cycle strobe, all results update together
//   timeout_flag_o       : loss-of-signal level
//   busy_o               : divider running
// slave = the capture block, master = whoever drives the PWM line.
interface pwm_capture_if #(
    parameter int nbits    = 10,
    parameter int cnt_bits = 24
);
    logic                en_i;
    logic                in_i;
    logic [cnt_bits-1:0] high_count_o;
    logic [cnt_bits-1:0] period_count_o;
    logic [nbits-1:0]    duty_o;
    logic                valid_o;
    logic                timeout_flag_o;
    logic                busy_o;

    modport slave (
        input  en_i, in_i,
        output high_count_o, period_count_o, duty_o, valid_o, timeout_flag_o, busy_o
    );

    modport master (
        output en_i, in_i,
        input  high_count_o, period_count_o, duty_o, valid_o, timeout_flag_o, busy_o
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and normalised duty of a PWM line.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : pwm_capture_if.slave (enable, PWM input, results, valid, flags)
// The input is synchronised (2 FF) and edge-detected in a third register, so
// both edges see the same 3-cycle latency and widths are exact. A restoring
// divider produces duty = floor(H * 2^nbits / P), one quotient bit per cycle.
module pwm_capture #(
    parameter int nbits          = 10,
    parameter int cnt_bits       = 24,
    parameter int timeout_cycles = 480000
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);

    if (!(nbits >= 2 && (nbits + 2) < timeout_cycles &&
          longint'(timeout_cycles) < (longint'(1) << cnt_bits))) begin : g_param_chk
        $error("pwm_capture: parameter constraint violated");
    end

    localparam int                  BW = $clog2(nbits);
    localparam logic [cnt_bits-1:0] TO = cnt_bits'(timeout_cycles);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state_q, state_d;

    logic                meta_q, sync_q, dly_q, rise_q, fall_q;
    logic [cnt_bits-1:0] cnt_q;
    logic                armed_q;
    logic [cnt_bits-1:0] shadow_q;
    logic [cnt_bits-1:0] rem_q, divisor_q, hop_q;
    logic [nbits-1:0]    quo_q;
    logic                sat_q;
    logic [BW-1:0]       bitcnt_q;
    logic [cnt_bits-1:0] high_q, period_q;
    logic [nbits-1:0]    duty_q;
    logic                flag_q, to_pulse_q;

    logic                start, finish, to_hit, ge;
    logic [cnt_bits:0]   rem_sh;
    logic [cnt_bits-1:0] diff, rem_nx;
    logic [nbits-1:0]    quo_nx;

    // A rise on an idle divider starts a measurement; a rise while busy is
    // simply dropped (cnt still restarts below).
    assign start  = armed_q && rise_q && (state_q == IDLE);
    assign finish = (state_q == DIV) && (bitcnt_q == BW'(nbits - 1));
    // flag_q gating makes loss-of-signal a single event until a real
    // measurement clears it. A coincident rise wins over the threshold.
    assign to_hit = (cnt_q == TO) && !rise_q && (state_q == IDLE) && !flag_q;

    // Restoring step. The remainder is always below the divisor, so the
    // difference fits in cnt_bits; the saturated case discards the quotient.
    always_comb begin
        rem_sh = {rem_q, 1'b0};
        ge     = rem_sh >= {1'b0, divisor_q};
        diff   = rem_sh[cnt_bits-1:0] - divisor_q;
        rem_nx = ge ? diff : rem_sh[cnt_bits-1:0];
        quo_nx = {quo_q[nbits-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = DIV;
            DIV:     if (finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.en_i) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            dly_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            shadow_q   <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            hop_q      <= '0;
            quo_q      <= '0;
            sat_q      <= 1'b0;
            bitcnt_q   <= '0;
            high_q     <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            flag_q     <= 1'b0;
            to_pulse_q <= 1'b0;
        end else begin
            // synchroniser and edge detect run regardless of en
            meta_q     <= bus.in_i;
            sync_q     <= meta_q;
            dly_q      <= sync_q;
            rise_q     <= sync_q & ~dly_q;
            fall_q     <= ~sync_q & dly_q;
            state_q    <= state_d;
            to_pulse_q <= 1'b0;

            if (!bus.en_i) begin
                cnt_q    <= '0;
                armed_q  <= 1'b0;
                shadow_q <= '0;
                flag_q   <= 1'b0;
            end else begin
                if (rise_q)            cnt_q <= cnt_bits'(1);
                else if (cnt_q != TO)  cnt_q <= cnt_q + cnt_bits'(1);

                if (rise_q)      armed_q <= 1'b1;
                else if (to_hit) armed_q <= 1'b0;

                if (fall_q && armed_q) shadow_q <= cnt_q;

                if (start) begin
                    rem_q     <= shadow_q;
                    divisor_q <= cnt_q;
                    hop_q     <= shadow_q;
                    sat_q     <= shadow_q >= cnt_q;
                    quo_q     <= '0;
                    bitcnt_q  <= '0;
                end else if (state_q == DIV) begin
                    rem_q    <= rem_nx;
                    quo_q    <= quo_nx;
                    bitcnt_q <= bitcnt_q + BW'(1);
                end

                // results land on the edge into DONE so they are visible
                // together with valid
                if (finish) begin
                    high_q   <= hop_q;
                    period_q <= divisor_q;
                    duty_q   <= sat_q ? '1 : quo_nx;
                    flag_q   <= 1'b0;
                end

                if (to_hit) begin
                    high_q     <= '0;
                    period_q   <= '0;
                    duty_q     <= {nbits{sync_q}};
                    flag_q     <= 1'b1;
                    to_pulse_q <= 1'b1;
                end
            end
        end
    end

    assign bus.high_count_o   = high_q;
    assign bus.period_count_o = period_q;
    assign bus.duty_o         = duty_q;
    assign bus.valid_o        = (state_q == DONE) | to_pulse_q;
    assign bus.timeout_flag_o = flag_q;
    assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM stimulus with a scoreboard of expected
// results (values and arrival cycle) checked by an independent monitor.
module tb_pwm_capture;
    localparam int NB = 10;
    localparam int CB = 24;
    localparam int TO = 2500;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture_if #(.nbits(NB), .cnt_bits(CB)) bus ();

    pwm_capture #(.nbits(NB), .cnt_bits(CB), .timeout_cycles(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int h;
        int p;
        int d;
        int f;
        int at;
    } exp_t;

    exp_t sb[$];
    int   nchk  = 0;
    int   npass = 0;
    bit   bchk  = 1'b1;
    int   run   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int p, input int d, input int f, input int at);
        exp_t e;
        e.h = h; e.p = p; e.d = d; e.f = f; e.at = at;
        sb.push_back(e);
    endtask

    // One PWM period starting with a rise now; c = cycle of the rise.
    task automatic pulse(input int hi, input int per, output int c);
        bus.in_i = 1'b1;
        c = cyc;
        repeat (hi) tick();
        bus.in_i = 1'b0;
        repeat (per - hi) tick();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_cycle",  cyc, e.at);
                chk("high_count",   bus.high_count_o, e.h);
                chk("period_count", bus.period_count_o, e.p);
                chk("duty",         bus.duty_o, e.d);
                chk("timeout_flag", bus.timeout_flag_o, e.f);
            end
        end
    end

    // Every completed division keeps busy high for DIV + DONE cycles
    always @(negedge clk) begin
        if (bus.busy_o) run++;
        else begin
            if (run > 0 && bchk) chk("busy_len", run, NB + 1);
            run = 0;
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        bus.en_i = 1'b1;
        bus.in_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_high",  bus.high_count_o, 0);
        chk("rst_per",   bus.period_count_o, 0);
        chk("rst_duty",  bus.duty_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_flag",  bus.timeout_flag_o, 0);
        chk("rst_busy",  bus.busy_o, 0);

        // 25% duty, 400-cycle period; first rise only arms
        pulse(100, 400, c);
        repeat (3) begin
            push(100, 400, 256, 0, cyc + 14);
            pulse(100, 400, c);
        end
        // line goes quiet low: one timeout strobe, no repeats
        push(0, 0, 0, 1, c + TO + 4);
        repeat (2 * TO) tick();

        // near-full duty, then held high into timeout
        pulse(399, 400, c);
        push(399, 400, 1021, 0, cyc + 14);
        pulse(399, 400, c);
        push(399, 400, 1021, 0, cyc + 14);
        bus.in_i = 1'b1;
        c = cyc;
        repeat (100) tick();
        chk("hold_high", bus.high_count_o, 399);
        chk("hold_per",  bus.period_count_o, 400);
        chk("hold_duty", bus.duty_o, 1021);
        push(0, 0, 1023, 1, c + TO + 4);
        repeat (TO) tick();

        // resume 50% / 1000: flag held until first new measurement
        bus.in_i = 1'b0;
        repeat (20) tick();
        pulse(500, 1000, c);
        chk("flag_kept", bus.timeout_flag_o, 1);
        repeat (2) begin
            push(500, 1000, 512, 0, cyc + 14);
            pulse(500, 1000, c);
        end
        push(0, 0, 0, 1, c + TO + 4);
        repeat (2 * TO) tick();

        // period 8: every other rise lands while busy and is dropped
        pulse(4, 8, c);
        repeat (3) begin
            push(4, 8, 512, 0, cyc + 14);
            pulse(4, 8, c);
            pulse(4, 8, c);
        end
        push(0, 0, 0, 1, c + TO + 4);
        repeat (TO + 50) tick();

        // reset 5 cycles into DIV: no strobe, everything back to zero
        pulse(100, 400, c);
        bchk = 1'b0;
        bus.in_i = 1'b1;
        repeat (8) tick();
        rst = 1'b1;
        bus.in_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_high",  bus.high_count_o, 0);
        chk("abort_per",   bus.period_count_o, 0);
        chk("abort_duty",  bus.duty_o, 0);
        chk("abort_flag",  bus.timeout_flag_o, 0);
        chk("abort_busy",  bus.busy_o, 0);
        chk("abort_valid", bus.valid_o, 0);
        bchk = 1'b1;
        repeat (20) tick();

        // held high after reset -> duty all ones, gives nonzero held result
        bus.in_i = 1'b1;
        c = cyc;
        push(0, 0, 1023, 1, c + TO + 4);
        repeat (TO + 20) tick();
        bus.in_i = 1'b0;
        repeat (20) tick();

        // en dropped mid-division: results held, flag cleared, no strobe
        pulse(100, 400, c);
        bchk = 1'b0;
        bus.in_i = 1'b1;
        repeat (8) tick();
        bus.en_i = 1'b0;
        repeat (3) tick();
        chk("en_high",  bus.high_count_o, 0);
        chk("en_per",   bus.period_count_o, 0);
        chk("en_duty",  bus.duty_o, 1023);
        chk("en_flag",  bus.timeout_flag_o, 0);
        chk("en_busy",  bus.busy_o, 0);
        chk("en_valid", bus.valid_o, 0);
        bus.en_i = 1'b1;
        bchk = 1'b1;
        repeat (89) tick();
        bus.in_i = 1'b0;
        repeat (300) tick();
        // first rise after re-enable only arms
        pulse(100, 400, c);
        push(100, 400, 256, 0, cyc + 14);
        pulse(100, 400, c);
        repeat (30) tick();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: high time, period and normalised duty cycle.
- Receive-side counterpart of the team's pwm generator. Reads RC-receiver and sensor PWM lines into the 48 MHz fabric.
- Results are in clk cycles, with duty scaled to an nbits code.
- Results go to the control loop with a one-cycle valid strobe and a loss-of-signal flag.

Parameters:
nbits, 10, duty resolution in bits; duty = floor(high_count * 2^nbits / period_count), saturated to 2^nbits-1
cnt_bits, 24, width of the high-time and period counters
timeout_cycles, 480000, cycles with no rising edge before loss of signal is declared (10 ms at 48 MHz); elaboration error unless nbits+2 < timeout_cycles < 2^cnt_bits

Ports:
clk  input  1  system clock (48 MHz)
rst  input  1  reset, synchronous, active-high
en  input  1  capture enable
in  input  1  asynchronous PWM input
high_count  output  cnt_bits  last measured high time, cycles
period_count  output  cnt_bits  last measured period (rise to rise), cycles
duty  output  nbits  last normalised duty
valid  output  1  one-cycle strobe; all three results update in the same cycle
timeout_flag  output  1  level; loss of signal
busy  output  1  divider running

Behaviour:
- Reset values: all outputs 0. Internal counter 0, state IDLE, disarmed.
- in passes through a 2-FF synchroniser, then an edge-detect register. Edge detect occurs 3 clk after the input transition; rise and fall see identical delay, so widths are exact.
- Cycle counter cnt:
  - On the rise-detect cycle, cnt <= 1. Otherwise cnt <= cnt+1, saturating at timeout_cycles.
  - The registered cnt at a fall detect is the high time H. At the next rise detect it is the period P.
- Fall detect while armed: H latched into a shadow register. Fall before the first rise is ignored.
- Rise detect:
  - If disarmed: arm only, no valid.
  - If armed and divider IDLE: latch P and shadow H, start the divider.
  - If armed and divider busy: this period is discarded. cnt still restarts and the divider keeps its operands.
- Divider FSM: IDLE -> DIV (exactly nbits cycles, restoring, one quotient bit per cycle) -> DONE (1 cycle) -> IDLE.
  - Dividend = H << nbits. Divisor = P. Quotient saturated to 2^nbits-1.
  - busy = 1 in DIV and DONE.
  - In DONE: valid = 1; high_count, period_count and duty load; timeout_flag cleared.
  - valid rises exactly nbits+1 cycles after the rise-detect cycle.
- Timeout:
  - Trigger: cnt reaches timeout_cycles, no rise detected, and the divider is IDLE (guaranteed by the parameter constraint).
  - Next cycle:
    - valid = 1 for one cycle.
    - high_count = 0 and period_count = 0.
    - duty = all ones if the synchronised in = 1, else 0.
    - timeout_flag = 1.
    - Disarm.
  - No further valid until a full period is measured: one rise to re-arm, then the next rise.
- en = 0:
  - Clears cnt, arm and shadow H, aborts the divider to IDLE, and clears timeout_flag.
  - Holds high_count, period_count and duty; valid = 0.
  - The synchroniser keeps running.
- rst mid-division: no valid is emitted; everything returns to reset values.
- Simultaneous rise detect and timeout threshold in the same cycle: the rise wins and timeout is not taken.
- Pulses shorter than 1 cycle after synchronisation may be missed; this is not an error.

Test Plan:
- nbits=10, period 400, high 100, repeated:
  - First rise -> no valid.
  - Second rise -> valid 11 cycles after detect, with high_count=100, period_count=400, duty=256, busy high for 11 cycles.
- High 399, period 400 -> duty=1021. Reported values stay stable until the next valid.
- in held high beyond 480000 cycles after a rise -> one valid pulse, duty=1023, counts=0, timeout_flag=1. Resume 50% / 1000-cycle PWM -> flag stays set until the first new valid (duty=512), then clears.
- in held low beyond the timeout -> single valid, duty=0, timeout_flag=1, no repeat pulses while still low.
- Period 8, high 4 (shorter than 12 cycles) -> rises during busy are dropped. Every valid reports period_count=8, high_count=4, duty=512, spaced at least 12 cycles apart.
- rst asserted 5 cycles into DIV -> no valid, all outputs 0. Repeat with en=0 -> no valid, previous results held, timeout_flag=0, first rise after en=1 only arms.
